mul_booth: RTL and testbench

Sequential 32x32 multiplier for the CPU datapath, the counterpart of the iterative divider. It takes two 32-bit operands on a start strobe, runs a radix-4 Booth recoding loop for 17 cycles, and returns the 64-bit product on Z. Z uses the same {HI, LO} layout the HI/LO register pair loads from the divider. Signed and unsigned multiplies share the same datapath.

---
 rtl/mul_booth.sv | 133 +++++++++++++
 tb/tb_mul_booth.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mul_booth.sv
// Sequential 32x32 radix-4 Booth multiplier, 17 steps per operation.
// Product returned on Z as {HI, LO}; signed and unsigned share one datapath.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; Z holds the last product
// RUN   | one Booth step per cycle, 17 steps in total
// DONE  | product on Z, done pulses for one cycle
module mul_booth #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int EW    = WIDTH + 2;        // extended operand width (34)
    localparam int AW    = 2 * EW;           // accumulator width (68)
    localparam int STEPS = EW / 2;           // Booth steps (17)
    localparam int SW    = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [EW-1:0]     mcand;
    logic [EW:0]       win;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_next;
    logic [SW-1:0]     step;
    logic              accept;
    logic              run_step;
    logic              last_step;
    logic [AW-1:0]     m_ext;
    logic [AW-1:0]     m_shift;
    logic [AW-1:0]     pp;
    logic [EW-1:0]     mcand_ext;
    logic [EW-1:0]     mplier_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        run_step   = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                run_step = 1'b1;
                if (step == SW'(STEPS - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mcand_ext  = is_signed ? {{2{Multiplicand[WIDTH-1]}}, Multiplicand}
                               : {2'b00, Multiplicand};
        mplier_ext = is_signed ? {{2{Multiplier[WIDTH-1]}}, Multiplier}
                               : {2'b00, Multiplier};
    end

    // Partial product: recoded digit times multiplicand, aligned to this step.
    always_comb begin
        m_ext   = {{(AW-EW){mcand[EW-1]}}, mcand};
        m_shift = m_ext << (2 * step);
        pp      = '0;
        case (win[2:0])
            3'b001, 3'b010: pp = m_shift;
            3'b011:         pp = m_shift << 1;
            3'b100:         pp = -(m_shift << 1);
            3'b101, 3'b110: pp = -m_shift;
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= '0;
            win   <= '0;
            acc   <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Z     <= '0;
        end else begin
            if (accept) begin
                mcand <= mcand_ext;
                win   <= {mplier_ext, 1'b0};
                acc   <= '0;
                step  <= '0;
                busy  <= 1'b1;
            end
            if (run_step) begin
                acc  <= acc_next;
                win  <= {{2{win[EW]}}, win[EW:2]};
                step <= step + SW'(1);
            end
            if (last_step) begin
                Z    <= acc_next[2*WIDTH-1:0];
                done <= 1'b1;
            end
            if (state == DONE) begin
                done <= 1'b0;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_booth.sv
// Self-checking bench for mul_booth: directed cases, busy/reset behaviour,
// and a randomized regression against a plain-arithmetic product model.
module tb_mul_booth;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic        busy;
    logic        done;
    logic [63:0] Z;

    int checks = 0;
    int errors = 0;

    mul_booth #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .is_signed    (is_signed),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .busy         (busy),
        .done         (done),
        .Z            (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction starting from IDLE; optionally toggles start and
    // operands at random while busy, which must have no effect.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input bit noise, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1; is_signed = s; Multiplicand = a; Multiplier = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        chk({tag, "_done_early"}, {63'd0, done}, 64'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (noise) begin
                start        = 1'($urandom_range(0, 1));
                is_signed    = 1'($urandom_range(0, 1));
                Multiplicand = $urandom;
                Multiplier   = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd17);
        chk({tag, "_z"}, Z, exp);
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_fall"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
        chk({tag, "_z_hold"}, Z, exp);
    endtask

    initial begin
        int          ndone;
        logic [63:0] zdone;
        logic [31:0] ra, rb;
        logic        rs;

        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0;
        Multiplicand = '0; Multiplier = '0;
        #23;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_z", Z, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        do_mul(32'd7, 32'd6, 1'b1, 64'h0000_0000_0000_002A, 1'b0, "s7x6");
        do_mul(32'hFFFF_FFFF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sm1x1");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0, "u_ones");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0, "s_ones");
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0, "s_min_sq");
        do_mul(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 1'b0, "u_min_x2");
        do_mul(32'd0, 32'h1234_5678, 1'b1, 64'd0, 1'b0, "zero_op");

        // start pulse with new operands in the middle of a running multiply
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; Multiplicand = 32'd100; Multiplier = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; zdone = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                start = 1'b1; Multiplicand = 32'd3; Multiplier = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                zdone = Z;
            end
        end
        start = 1'b0;
        chk("busy_start_done_count", 64'(ndone), 64'd1);
        chk("busy_start_z", zdone, 64'd10000);
        chk("busy_start_z_hold", Z, 64'd10000);

        // asynchronous reset in the middle of step 8
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; Multiplicand = 32'd1000; Multiplier = 32'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_z", Z, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("midreset_no_done", 64'(ndone), 64'd0);
        do_mul(32'd2, 32'd3, 1'b1, 64'd6, 1'b0, "after_reset");

        // random regression against the plain-arithmetic product
        for (int n = 0; n < 3000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                default: ;
            endcase
            do_mul(ra, rb, rs, ref_prod(ra, rb, rs), 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
